// File: rtl/agg_pkg.sv
// Types and helpers shared by the chunked-aggregator sweep controller and its users.
package agg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } agg_state_e;

  // Keys are zero-extended to this width before comparison.
  localparam int KEY_MAX_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when key a strictly beats key b; ties never win.
  function automatic logic better(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b,
                                  input logic                 min_wins);
    return min_wins ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/agg_tag_pipe.sv
// DEPTH-stage valid/last tag delay matching the aggregator latency; wires at depth 0.
module agg_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr_i,
  input  logic vld_i,
  input  logic last_i,
  output logic vld_o,
  output logic last_o
);

  if (DEPTH == 0) begin : g_wire
    assign vld_o  = vld_i;
    assign last_o = last_i;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge clk) begin
      if (clr_i) begin
        vld_q  <= '0;
        last_q <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every stage sampling the pre-edge value.
        vld_q  <= DEPTH'({vld_q, vld_i});
        last_q <= DEPTH'({last_q, last_i});
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];
  end

endmodule

// File: rtl/agg_sweep_ctrl.sv
// Sweeps chunk indices through a pipelined binary aggregator and folds the
// per-chunk winners into one global winner, reported with a start/done handshake.
module agg_sweep_ctrl
  import agg_pkg::*;
#(
  parameter int  CHUNK_CNT   = 8,
  parameter int  KEY_WIDTH   = 6,
  parameter int  DATA_WIDTH  = 16,
  parameter int  AGG_LATENCY = 2,
  parameter bit  MIN_WINS    = 1'b1,
  localparam int IDX_W       = clog2_min1(CHUNK_CNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  issue_vld,
  output logic [IDX_W-1:0]      issue_idx,
  input  logic                  agg_vld,
  input  logic [KEY_WIDTH-1:0]  agg_key,
  input  logic [DATA_WIDTH-1:0] agg_data,
  output logic                  done,
  output logic                  result_vld,
  output logic [KEY_WIDTH-1:0]  result_key,
  output logic [DATA_WIDTH-1:0] result_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_CNT - 1);

  agg_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  best_vld_q, best_vld_d;
  logic [KEY_WIDTH-1:0]  best_key_q, best_key_d;
  logic [DATA_WIDTH-1:0] best_data_q, best_data_d;
  logic                  res_vld_q, res_vld_d;
  logic [KEY_WIDTH-1:0]  res_key_q, res_key_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

  logic last_issue;
  logic tag_vld;
  logic tag_last;

  assign issue_vld  = (state_q == ST_ISSUE);
  assign last_issue = issue_vld && (idx_q == LAST_IDX);

  // Abort flushes in-flight tags so a later search never samples stale chunks.
  agg_tag_pipe #(
    .DEPTH (AGG_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .clr_i  (rst | abort),
    .vld_i  (issue_vld),
    .last_i (last_issue),
    .vld_o  (tag_vld),
    .last_o (tag_last)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    best_vld_d  = best_vld_q;
    best_key_d  = best_key_q;
    best_data_d = best_data_q;
    res_vld_d   = res_vld_q;
    res_key_d   = res_key_q;
    res_data_d  = res_data_q;

    // Strict compare: on equal keys the earlier chunk stays the winner.
    if (tag_vld && agg_vld &&
        (!best_vld_q || better(KEY_MAX_W'(agg_key), KEY_MAX_W'(best_key_q), MIN_WINS))) begin
      best_vld_d  = 1'b1;
      best_key_d  = agg_key;
      best_data_d = agg_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_ISSUE;
          idx_d       = '0;
          best_vld_d  = 1'b0;
          best_key_d  = '0;
          best_data_d = '0;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = (AGG_LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (tag_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Load on entry to DONE so the result includes the final chunk's merge.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      res_vld_d  = best_vld_d;
      res_key_d  = best_key_d;
      res_data_d = best_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      best_vld_q  <= 1'b0;
      best_key_q  <= '0;
      best_data_q <= '0;
      res_vld_q   <= 1'b0;
      res_key_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_vld_q  <= best_vld_d;
      best_key_q  <= best_key_d;
      best_data_q <= best_data_d;
      res_vld_q   <= res_vld_d;
      res_key_q   <= res_key_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign issue_idx   = idx_q;
  assign result_vld  = res_vld_q;
  assign result_key  = res_key_q;
  assign result_data = res_data_q;

endmodule
